scan_shift_tx: RTL and testbench
================================

SCAN_SHIFT_TX -- requirements
Module: scan_shift_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits shifted per frame (legal 2..32).
REQ-002 Parameter MSB_FIRST, default 0; 0 = bit 0 shifted first, 1 = bit WIDTH-1 shifted first.
REQ-003 CLk  input  1  single clock, all state updates on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous assert, active-low.
REQ-005 load_valid  input  1  parallel word offered.
REQ-006 load_data  input  WIDTH  word to serialize, sampled only on accept.
REQ-007 load_ready  output  1  block can accept a word.
REQ-008 abort  input  1  synchronous cancel of a frame in progress.
REQ-009 SD  output  1  serial data toward the storage-element chain.
REQ-010 SLn  output  1  active-low shift select, low for every cycle SD carries a valid bit.
REQ-011 EN  output  1  chain enable, high exactly when SLn is low.
REQ-012 done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 States SHALL be IDLE, SHIFT, PAR (present only with the macro in REQ-030), and DONE; all outputs SHALL be registered.
REQ-014 IDLE: load_ready=1, SLn=1, EN=0, SD=0, done=0.
REQ-015 Accept occurs on a rising edge with state=IDLE and load_valid=1; the word is captured into a shift register, the bit counter is loaded with WIDTH, and the state moves to SHIFT.
REQ-016 load_ready SHALL drop to 0 in the cycle after accept and remain 0 until the state returns to IDLE.
REQ-017 SHIFT: the first data bit SHALL appear on SD in the cycle immediately after accept (latency 1), with SLn=0 and EN=1.
REQ-018 One bit is emitted per cycle in the order set by MSB_FIRST, for exactly WIDTH consecutive cycles with no gaps.
REQ-019 The bit counter width SHALL be $clog2(WIDTH+1); it decrements once per emitted bit and never wraps below 0.
REQ-020 After the last data bit the state goes to PAR if the macro is compiled in, else to DONE.
REQ-021 DONE lasts one cycle: done=1, SLn=1, EN=0, SD=0; the next state is IDLE.
REQ-022 abort=1 in SHIFT or PAR: the next state is IDLE, SLn=1 and EN=0 from the next cycle, done is not asserted, and the remaining bits are discarded.
REQ-023 abort=1 in IDLE or DONE SHALL have no effect; abort and load_valid together in IDLE SHALL accept the word.
REQ-024 load_valid in any state other than IDLE SHALL be ignored; load_data changes after accept SHALL not affect the frame.
REQ-025 Back-to-back frames: the minimum accept-to-accept spacing is WIDTH+2 cycles (WIDTH+3 with the macro).

Reset
REQ-026 RSTn=0 SHALL immediately force state=IDLE, counter=0, shift register=0, SD=0, SLn=1, EN=0, done=0, and load_ready=0, regardless of CLk.
REQ-027 load_ready SHALL rise to 1 on the first rising CLk edge after RSTn returns high.
REQ-028 RSTn asserted mid-frame SHALL abandon the frame without a done pulse; no partial-frame state survives reset.
REQ-029 No output SHALL glitch low on SLn during or after reset release.

Configuration
REQ-030 Macro SCAN_TX_PARITY_EN: when defined, PAR follows the last data bit for one cycle with SD = XOR of all captured data bits (even parity), SLn=0, EN=1; when undefined, PAR does not exist and frames are exactly WIDTH bits.

Verification
REQ-031 WIDTH=8, MSB_FIRST=0, accept 0xA5 -> SD=1,0,1,0,0,1,0,1 on cycles 1-8 with SLn=0 and EN=1, done=1 on cycle 9, load_ready=1 on cycle 10.
REQ-032 MSB_FIRST=1, accept 0x81 -> SD=1,0,0,0,0,0,0,1; with SCAN_TX_PARITY_EN, cycle 9 SD=0 and done on cycle 10.
REQ-033 Accept 0xFF, abort on shift cycle 3 -> SLn=1 from cycle 4, no done pulse, load_ready=1 and next word accepted.
REQ-034 RSTn pulled low on shift cycle 5 between clock edges -> SLn=1, EN=0, load_ready=0 immediately; load_ready=1 after the first edge following release.
REQ-035 load_valid held at 1 continuously with alternating words 0x0F/0xF0 -> accepts spaced exactly WIDTH+2 cycles, each frame correct, load_data changes mid-frame ignored.

Source files
------------

// File: rtl/scan_shift_tx.sv
// Parallel-to-serial transmitter that loads a scan/storage-element chain one bit per clock.
// Optional trailing even-parity bit is compiled in with the SCAN_TX_PARITY_EN macro.
module scan_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLk,
  input  logic             RSTn,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             SD,
  output logic             SLn,
  output logic             EN,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef SCAN_TX_PARITY_EN
    , PAR = 2'd3
`endif
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sd_nx;
`ifdef SCAN_TX_PARITY_EN
  logic             par, par_nx;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // SD is registered, so the bit for the coming cycle is chosen here from the
  // next state: on accept the first bit leaves directly from load_data.
  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    cnt_nx   = cnt;
    sd_nx    = 1'b0;
`ifdef SCAN_TX_PARITY_EN
    par_nx   = par;
`endif
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nx = SHIFT;
          sh_nx    = shift_out(load_data);
          cnt_nx   = CW'(WIDTH);
          sd_nx    = first_bit(load_data);
`ifdef SCAN_TX_PARITY_EN
          par_nx   = ^load_data;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
          sh_nx    = {WIDTH{1'b0}};
          cnt_nx   = {CW{1'b0}};
        end else if (cnt > CW'(1)) begin
          sd_nx    = first_bit(sh);
          sh_nx    = shift_out(sh);
          cnt_nx   = cnt - CW'(1);
        end else begin
          cnt_nx   = {CW{1'b0}};
`ifdef SCAN_TX_PARITY_EN
          state_nx = PAR;
          sd_nx    = par;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef SCAN_TX_PARITY_EN
      PAR: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
        sh_nx = {WIDTH{1'b0}};
      end
`endif
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        sh_nx    = {WIDTH{1'b0}};
        cnt_nx   = {CW{1'b0}};
      end
    endcase
  end

  // State, datapath and all outputs registered; reset parks the chain deselected.
  always_ff @(posedge CLk or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      sh         <= {WIDTH{1'b0}};
      cnt        <= {CW{1'b0}};
      SD         <= 1'b0;
      SLn        <= 1'b1;
      EN         <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
`ifdef SCAN_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      sh         <= sh_nx;
      cnt        <= cnt_nx;
      SD         <= sd_nx;
`ifdef SCAN_TX_PARITY_EN
      par        <= par_nx;
      SLn        <= !((state_nx == SHIFT) || (state_nx == PAR));
      EN         <= (state_nx == SHIFT) || (state_nx == PAR);
`else
      SLn        <= !(state_nx == SHIFT);
      EN         <= (state_nx == SHIFT);
`endif
      done       <= (state_nx == DONE);
      load_ready <= (state_nx == IDLE);
    end
  end

endmodule

// File: tb/tb_scan_shift_tx.sv
// Directed bench for scan_shift_tx: an LSB-first and an MSB-first instance share stimulus.
module tb_scan_shift_tx;
  localparam int W = 8;
`ifdef SCAN_TX_PARITY_EN
  localparam int PEXTRA = 1;
`else
  localparam int PEXTRA = 0;
`endif

  logic         CLk = 1'b0;
  logic         RSTn;
  logic         load_valid;
  logic         abort;
  logic [W-1:0] load_data;
  logic         rdy_l, sd_l, sln_l, en_l, done_l;
  logic         rdy_m, sd_m, sln_m, en_m, done_m;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] el;
    logic [7:0] em;
    logic       ep;
    logic       ab_load;
    logic       ab_done;
  } vec_t;
  vec_t tbl [6];

  scan_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .CLk(CLk), .RSTn(RSTn), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_l), .abort(abort), .SD(sd_l), .SLn(sln_l), .EN(en_l), .done(done_l));

  scan_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .CLk(CLk), .RSTn(RSTn), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_m), .abort(abort), .SD(sd_m), .SLn(sln_m), .EN(en_m), .done(done_m));

  always #5 CLk = ~CLk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {SD, SLn, EN, done, load_ready}
  function automatic logic [4:0] outs_l();
    return {sd_l, sln_l, en_l, done_l, rdy_l};
  endfunction

  function automatic logic [4:0] outs_m();
    return {sd_m, sln_m, en_m, done_m, rdy_m};
  endfunction

  task automatic run_frame(input vec_t v);
    @(negedge CLk);
    chk("pre_idle_l", 32'(outs_l()), 32'(5'b01001));
    chk("pre_idle_m", 32'(outs_m()), 32'(5'b01001));
    load_valid = 1'b1;
    load_data  = v.d;
    abort      = v.ab_load;
    @(posedge CLk);
    #1;
    load_valid = 1'b0;
    abort      = 1'b0;
    load_data  = ~v.d;
    for (int i = 0; i < W; i++) begin
      @(negedge CLk);
      chk("shift_l", 32'(outs_l()), 32'({v.el[i], 4'b0100}));
      chk("shift_m", 32'(outs_m()), 32'({v.em[i], 4'b0100}));
      if (i == 2) load_valid = 1'b1;
      if (i == 5) load_valid = 1'b0;
    end
`ifdef SCAN_TX_PARITY_EN
    @(negedge CLk);
    chk("par_l", 32'(outs_l()), 32'({v.ep, 4'b0100}));
    chk("par_m", 32'(outs_m()), 32'({v.ep, 4'b0100}));
`endif
    @(posedge CLk);
    #1;
    abort = v.ab_done;
    @(negedge CLk);
    chk("done_l", 32'(outs_l()), 32'(5'b01010));
    chk("done_m", 32'(outs_m()), 32'(5'b01010));
    @(posedge CLk);
    #1;
    abort = 1'b0;
    @(negedge CLk);
    chk("post_idle_l", 32'(outs_l()), 32'(5'b01001));
    chk("post_idle_m", 32'(outs_m()), 32'(5'b01001));
  endtask

  initial begin
    logic [7:0] cur;
    time        t_acc;
    time        t_last;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h81, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h0F, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h3A, 8'h3A, 8'h5C, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h07, 8'h07, 8'hE0, 1'b1, 1'b1, 1'b1};

    RSTn       = 1'b0;
    load_valid = 1'b0;
    abort      = 1'b0;
    load_data  = 8'h00;
    #12;
    chk("reset_l", 32'(outs_l()), 32'(5'b01000));
    chk("reset_m", 32'(outs_m()), 32'(5'b01000));
    @(negedge CLk);
    RSTn = 1'b1;
    @(posedge CLk);
    #1;
    chk("release_l", 32'(outs_l()), 32'(5'b01001));

    for (int k = 0; k < 6; k++) run_frame(tbl[k]);

    // Abort on shift cycle 3, then a normal frame must be accepted
    @(negedge CLk);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(posedge CLk);
    #1;
    load_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) abort = 1'b1;
      @(negedge CLk);
      chk("abort_shift_l", 32'(outs_l()), 32'(5'b10100));
      @(posedge CLk);
      #1;
    end
    abort = 1'b0;
    @(negedge CLk);
    chk("abort_c4_l", 32'(outs_l()), 32'(5'b01001));
    chk("abort_c4_m", 32'(outs_m()), 32'(5'b01001));
    @(negedge CLk);
    chk("abort_c5_l", 32'(outs_l()), 32'(5'b01001));
    run_frame(tbl[0]);

    // Back-to-back with load_valid held high and alternating words
    @(negedge CLk);
    load_valid = 1'b1;
    load_data  = 8'h0F;
    cur        = 8'h0F;
    t_last     = 0;
    for (int f = 0; f < 3; f++) begin
      chk("b2b_ready", 32'(rdy_l), 32'd1);
      @(posedge CLk);
      t_acc = $time;
      if (f > 0) chk("b2b_spacing", 32'((t_acc - t_last) / 10), 32'(W + 2 + PEXTRA));
      t_last = t_acc;
      #1;
      load_data = 8'h55;
      for (int i = 0; i < W; i++) begin
        @(negedge CLk);
        chk("b2b_l", 32'(outs_l()), 32'({cur[i], 4'b0100}));
        chk("b2b_m", 32'(outs_m()), 32'({cur[W-1-i], 4'b0100}));
        if (i == 3) load_data = ~cur;
      end
`ifdef SCAN_TX_PARITY_EN
      @(negedge CLk);
      chk("b2b_par", 32'(outs_l()), 32'({^cur, 4'b0100}));
`endif
      @(negedge CLk);
      chk("b2b_done", 32'(outs_l()), 32'(5'b01010));
      @(negedge CLk);
      cur = ~cur;
    end
    load_valid = 1'b0;

    // Reset between edges on shift cycle 5
    @(negedge CLk);
    load_valid = 1'b1;
    load_data  = 8'hC3;
    @(posedge CLk);
    #1;
    load_valid = 1'b0;
    repeat (5) @(negedge CLk);
    #2;
    RSTn = 1'b0;
    #1;
    chk("midrst_l", 32'(outs_l()), 32'(5'b01000));
    chk("midrst_m", 32'(outs_m()), 32'(5'b01000));
    @(posedge CLk);
    @(negedge CLk);
    chk("midrst_hold", 32'(outs_l()), 32'(5'b01000));
    RSTn = 1'b1;
    @(posedge CLk);
    #1;
    chk("midrst_rel_l", 32'(outs_l()), 32'(5'b01001));
    @(negedge CLk);
    chk("midrst_idle_l", 32'(outs_l()), 32'(5'b01001));
    chk("midrst_idle_m", 32'(outs_m()), 32'(5'b01001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
